// File: rtl/exec_unit_pipe.sv
// Execute stage: single-cycle ALU ops, predicated on an internal C/Z flag register,
// plus an optional shift-add multiplier; results leave through a valid/ready output register.
module exec_unit_pipe #(
    parameter int W      = 16,
    parameter int IMM_W  = 9,
    parameter int RA_W   = 3,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [W-1:0]     in_opa,
    input  logic [W-1:0]     in_opb,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [RA_W-1:0]  in_dest,
    input  logic [1:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [W-1:0]     out_opa,
    output logic [RA_W-1:0]  out_dest,
    output logic [1:0]       out_tag,
    output logic             out_wr_en,
    output logic             flag_c,
    output logic             flag_z
);
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_HOLD = 2'd2} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*W-1:0]    mcand_q, acc_q, acc_d, mul_final_d;
    logic [W-1:0]      mplier_q, mopa_q;
    logic [RA_W-1:0]   mdest_q;
    logic [1:0]        mtag_q;

    logic              out_valid_q, out_wr_en_q, flag_c_q, flag_z_q;
    logic [W-1:0]      out_result_q, out_opa_q;
    logic [RA_W-1:0]   out_dest_q;
    logic [1:0]        out_tag_q;

    logic [W:0]        add_sum_d, adl_sum_d;
    logic [W-1:0]      alu_res_d;
    logic              add_en_d, adl_en_d, nand_en_d, lhi_en_d, is_mul_d;
    logic              alu_wr_d, alu_c_d, alu_z_d;
    logic              slot_free, accept, mul_last;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == S_IDLE) && slot_free;
    assign accept    = in_valid && in_ready && !flush;

    // Predicates read the flag register directly; flags of an accepted op land on
    // its accept edge, so the very next instruction already sees them.
    always_comb begin
        add_sum_d = {1'b0, in_opa} + {1'b0, in_opb};
        adl_sum_d = {1'b0, in_opa} + {1'b0, in_opb << 1};
        add_en_d  = 1'b0;
        adl_en_d  = 1'b0;
        nand_en_d = 1'b0;
        lhi_en_d  = 1'b0;
        is_mul_d  = 1'b0;
        case (in_op)
            5'b00001: add_en_d  = 1'b1;
            5'b00010: add_en_d  = flag_c_q;
            5'b00011: add_en_d  = flag_z_q;
            5'b00100: adl_en_d  = 1'b1;
            5'b00101: nand_en_d = 1'b1;
            5'b00110: nand_en_d = flag_c_q;
            5'b00111: nand_en_d = flag_z_q;
            5'b01000: lhi_en_d  = 1'b1;
            5'b01001: is_mul_d  = MUL_EN;
            default:  is_mul_d  = 1'b0;
        endcase
        if (add_en_d)       alu_res_d = add_sum_d[W-1:0];
        else if (adl_en_d)  alu_res_d = adl_sum_d[W-1:0];
        else if (nand_en_d) alu_res_d = ~(in_opa & in_opb);
        else if (lhi_en_d)  alu_res_d = {in_imm, {(W-IMM_W){1'b0}}};
        else                alu_res_d = '0;
        alu_wr_d = add_en_d || adl_en_d || nand_en_d || lhi_en_d;
        alu_c_d  = add_en_d ? add_sum_d[W] : adl_sum_d[W];
        alu_z_d  = (alu_res_d == '0);
    end

    assign acc_d       = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_final_d = (state_q == S_HOLD) ? acc_q : acc_d;
    assign mul_last    = (cnt_q == CNT_W'(W-1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mcand_q      <= '0;
            acc_q        <= '0;
            mplier_q     <= '0;
            mopa_q       <= '0;
            mdest_q      <= '0;
            mtag_q       <= '0;
            out_valid_q  <= 1'b0;
            out_wr_en_q  <= 1'b0;
            out_result_q <= '0;
            out_opa_q    <= '0;
            out_dest_q   <= '0;
            out_tag_q    <= '0;
            flag_c_q     <= 1'b0;
            flag_z_q     <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            out_wr_en_q <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
        end else begin
            if (out_ready) begin
                out_valid_q <= 1'b0;
                out_wr_en_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept && is_mul_d) begin
                        mcand_q  <= {{W{1'b0}}, in_opa};
                        mplier_q <= in_opb;
                        mopa_q   <= in_opa;
                        mdest_q  <= in_dest;
                        mtag_q   <= in_tag;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_BUSY;
                    end else if (accept) begin
                        out_valid_q  <= 1'b1;
                        out_wr_en_q  <= alu_wr_d;
                        out_result_q <= alu_res_d;
                        out_opa_q    <= in_opa;
                        out_dest_q   <= in_dest;
                        out_tag_q    <= in_tag;
                        if (add_en_d || adl_en_d) flag_c_q <= alu_c_d;
                        if (add_en_d || adl_en_d || nand_en_d) flag_z_q <= alu_z_d;
                    end
                end
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (mul_last && slot_free) begin
                        out_valid_q  <= 1'b1;
                        out_wr_en_q  <= 1'b1;
                        out_result_q <= mul_final_d[W-1:0];
                        out_opa_q    <= mopa_q;
                        out_dest_q   <= mdest_q;
                        out_tag_q    <= mtag_q;
                        flag_c_q     <= |mul_final_d[2*W-1:W];
                        flag_z_q     <= (mul_final_d[W-1:0] == '0);
                        state_q      <= S_IDLE;
                    end else if (mul_last) begin
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Product already sits in acc_q; wait for the output slot.
                    if (slot_free) begin
                        out_valid_q  <= 1'b1;
                        out_wr_en_q  <= 1'b1;
                        out_result_q <= mul_final_d[W-1:0];
                        out_opa_q    <= mopa_q;
                        out_dest_q   <= mdest_q;
                        out_tag_q    <= mtag_q;
                        flag_c_q     <= |mul_final_d[2*W-1:W];
                        flag_z_q     <= (mul_final_d[W-1:0] == '0);
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_wr_en  = out_wr_en_q;
    assign out_result = out_result_q;
    assign out_opa    = out_opa_q;
    assign out_dest   = out_dest_q;
    assign out_tag    = out_tag_q;
    assign flag_c     = flag_c_q;
    assign flag_z     = flag_z_q;

endmodule
